// File: rtl/mat_vec_res_unload_pkg.sv
// Shared parameters for the result unloader: parameter-set tables,
// word/byte derivation, FSM state encoding and a clog2 helper.
package mat_vec_res_unload_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    function automatic int vec_bytes(input string ps);
        if (ps == "L1") return 126;
        if (ps == "L3") return 193;
        if (ps == "L5") return 278;
        return 8;
    endfunction

    function automatic int nwords(input int vs, input int ngf);
        return (vs + ngf - 1) / ngf;
    endfunction

    function automatic int last_bytes(input int vs, input int ngf);
        return vs - (nwords(vs, ngf) - 1) * ngf;
    endfunction

    // Nominal width is clog2(VEC_SIZE_BYTES*8/PROC_SIZE); widened only if
    // the final (partial) word index would not otherwise fit.
    function automatic int addr_width(input int vs, input int ngf);
        int w;
        int m;
        w = clog2((vs * 8) / (ngf * 8));
        m = clog2(nwords(vs, ngf));
        if (m > w) w = m;
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/mat_vec_res_unload.sv
// Result unloader: reads multiplier result words and streams them out
// MSB-first as bytes over a valid/ready handshake, trimming tail padding.
module mat_vec_res_unload
    import mat_vec_res_unload_pkg::*;
#(
    parameter string PARAMETER_SET  = "L3",
    parameter int    VEC_SIZE_BYTES = vec_bytes(PARAMETER_SET),
    parameter int    N_GF           = 8,
    localparam int   PROC_SIZE      = N_GF * 8,
    localparam int   ADDR_W         = addr_width(VEC_SIZE_BYTES, N_GF)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_res_en,
    output logic [ADDR_W-1:0]    o_res_addr,
    input  logic [PROC_SIZE-1:0] i_res,
    output logic [7:0]           o_byte,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int NWORDS     = nwords(VEC_SIZE_BYTES, N_GF);
    localparam int LAST_BYTES = last_bytes(VEC_SIZE_BYTES, N_GF);
    localparam int CNT_W      = clog2(N_GF + 1);

    state_t                 r_state;
    state_t                 w_nxt_state;
    logic                   r_res_en;
    logic [ADDR_W-1:0]      r_res_addr;
    logic [PROC_SIZE-1:0]   r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_valid;
    logic                   r_last;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_res_en;
    logic [ADDR_W-1:0]      w_res_addr;
    logic [PROC_SIZE-1:0]   w_shift;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_valid;
    logic                   w_last;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_last_word;
    logic [CNT_W-1:0]       w_wbytes;

    // The address register doubles as the word index.
    assign w_last_word = (r_res_addr == ADDR_W'(NWORDS - 1));
    assign w_wbytes    = w_last_word ? CNT_W'(LAST_BYTES) : CNT_W'(N_GF);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_nxt_state;
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_nxt_state = r_state;
        w_res_en    = 1'b0;
        w_res_addr  = r_res_addr;
        w_shift     = r_shift;
        w_cnt       = r_cnt;
        w_valid     = r_valid;
        w_last      = r_last;
        w_busy      = r_busy;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nxt_state = S_FETCH;
                    w_res_en    = 1'b1;
                    w_res_addr  = '0;
                    w_busy      = 1'b1;
                end
            end
            S_FETCH: begin
                w_nxt_state = S_WAIT;
            end
            S_WAIT: begin
                w_nxt_state = S_SHIFT;
                w_shift     = i_res;
                w_cnt       = '0;
                w_valid     = 1'b1;
                w_last      = w_last_word && (LAST_BYTES == 1);
            end
            S_SHIFT: begin
                if (r_valid && i_ready) begin
                    w_shift = {r_shift[PROC_SIZE-9:0], 8'h00};
                    w_cnt   = r_cnt + CNT_W'(1);
                    if (r_cnt == w_wbytes - CNT_W'(1)) begin
                        w_valid = 1'b0;
                        w_last  = 1'b0;
                        if (w_last_word) begin
                            w_nxt_state = S_DONE;
                            w_busy      = 1'b0;
                            w_done      = 1'b1;
                        end else begin
                            w_nxt_state = S_FETCH;
                            w_res_en    = 1'b1;
                            w_res_addr  = r_res_addr + ADDR_W'(1);
                        end
                    end else begin
                        w_last = w_last_word
                              && (r_cnt + CNT_W'(2) == w_wbytes);
                    end
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_en   <= 1'b0;
            r_res_addr <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_res_en   <= w_res_en;
            r_res_addr <= w_res_addr;
            r_shift    <= w_shift;
            r_cnt      <= w_cnt;
            r_valid    <= w_valid;
            r_last     <= w_last;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    assign o_res_en   = r_res_en;
    assign o_res_addr = r_res_addr;
    assign o_byte     = r_shift[PROC_SIZE-1 -: 8];
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_mat_vec_res_unload.sv
// Scoreboard bench for mat_vec_res_unload: L3 and L1 instances, memory
// models, byte-stream reference built from memory contents.
module tb_mat_vec_res_unload;

    typedef struct packed {
        logic [7:0] b;
        logic       l;
    } exp_t;

    localparam int VS3 = 193;
    localparam int NW3 = 25;
    localparam int VS1 = 126;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // L3 instance
    logic        start = 1'b0;
    logic        res_en;
    logic [4:0]  addr;
    logic [63:0] res = '0;
    logic [7:0]  byt;
    logic        valid;
    logic        ready = 1'b1;
    logic        last;
    logic        busy;
    logic        done;

    mat_vec_res_unload #(.PARAMETER_SET("L3"), .N_GF(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_res_en(res_en), .o_res_addr(addr), .i_res(res),
        .o_byte(byt), .o_valid(valid), .i_ready(ready),
        .o_last(last), .o_busy(busy), .o_done(done)
    );

    // L1 instance
    logic        start1 = 1'b0;
    logic        res_en1;
    logic [3:0]  addr1;
    logic [63:0] res1 = '0;
    logic [7:0]  byt1;
    logic        valid1;
    logic        ready1 = 1'b1;
    logic        last1;
    logic        busy1;
    logic        done1;

    mat_vec_res_unload #(.PARAMETER_SET("L1"), .N_GF(8)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1),
        .o_res_en(res_en1), .o_res_addr(addr1), .i_res(res1),
        .o_byte(byt1), .o_valid(valid1), .i_ready(ready1),
        .o_last(last1), .o_busy(busy1), .o_done(done1)
    );

    logic [63:0] mem3 [32];
    logic [63:0] mem1 [16];
    always @(posedge clk) if (res_en)  res  <= mem3[addr];
    always @(posedge clk) if (res_en1) res1 <= mem1[addr1];

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: byte b of the vector is byte (b%8) of word b/8,
    // counted from the most significant end.
    exp_t q[$];
    exp_t q1[$];

    task automatic push_exp3();
        exp_t e;
        logic [63:0] w;
        for (int b = 0; b < VS3; b++) begin
            w = mem3[b / 8];
            e.b = 8'(w >> (56 - 8 * (b % 8)));
            e.l = (b == VS3 - 1);
            q.push_back(e);
        end
    endtask

    task automatic push_exp1();
        exp_t e;
        logic [63:0] w;
        for (int b = 0; b < VS1; b++) begin
            w = mem1[b / 8];
            e.b = 8'(w >> (56 - 8 * (b % 8)));
            e.l = (b == VS1 - 1);
            q1.push_back(e);
        end
    endtask

    // Monitor state
    int   t0 = 0;
    int   rd_idx = 0;
    int   nbytes = 0;
    int   done_cnt = 0;
    bit   chk_timing = 1'b0;
    bit   rnd_ready = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_b = '0;
    logic prev_l = 1'b0;

    always @(posedge clk) begin
        #1;
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // L3 monitor: sampled at the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", valid, 1);
                chk("hold_byte", byt, prev_b);
                chk("hold_last", last, prev_l);
            end
            if (res_en) begin
                chk("rd_addr", addr, rd_idx);
                if (chk_timing && rd_idx == 0)
                    chk("first_rd_cycle", cyc - t0, 1);
                rd_idx++;
            end
            if (valid && ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_byte", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("byte", byt, e.b);
                    chk("last", last, e.l);
                end
                nbytes++;
                if (chk_timing && nbytes == 1)
                    chk("first_valid_cycle", cyc - t0, 3);
                if (chk_timing && last)
                    chk("last_cycle", cyc - t0, 243);
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", busy, 0);
                if (chk_timing) chk("done_cycle", cyc - t0, 244);
            end
            prev_stall = valid && !ready;
            prev_b = byt;
            prev_l = last;
        end
    end

    int nbytes1 = 0;
    int done1_cnt = 0;

    // L1 monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    chk("l1_unexpected_byte", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("l1_byte", byt1, e.b);
                    chk("l1_last", last1, e.l);
                end
                nbytes1++;
            end
            if (done1) done1_cnt++;
        end
    end

    task automatic load3(input bit special);
        for (int w = 0; w < 32; w++) mem3[w] = {$urandom, $urandom};
        if (special) begin
            mem3[0]  = 64'h0102030405060708;
            mem3[24] = 64'hAA00000000000000;
        end
    endtask

    task automatic begin_run3();
        push_exp3();
        rd_idx = 0;
        nbytes = 0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: plain, 1: random ready, 2: stray start pulses mid-run
    task automatic run3(input int mode, input bit special);
        load3(special);
        rnd_ready = (mode == 1);
        chk_timing = (mode != 1);
        begin_run3();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(posedge clk);
            #1;
            start = (mode == 2) && (i == 20 || i == 120);
        end
        start = 1'b0;
        rnd_ready = 1'b0;
        repeat (20) @(posedge clk);
        chk("run_done_count", done_cnt, 1);
        chk("run_bytes", nbytes, VS3);
        chk("run_reads", rd_idx, NW3);
        chk("run_queue_empty", q.size(), 0);
        chk("run_idle_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_en", res_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_byte", byt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("post_rst_idle_valid", valid, 0);

        run3(0, 1'b1);
        run3(1, 1'b0);
        run3(2, 1'b0);

        // Reset in the middle of word 10.
        load3(1'b0);
        chk_timing = 1'b0;
        begin_run3();
        for (int i = 0; i < 500 && rd_idx < 11; i++) @(posedge clk);
        chk("reached_word10", rd_idx, 11);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_res_en", res_en, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_byte", byt, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_last", last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nbytes = 0;
        repeat (30) @(posedge clk);
        chk("post_midrst_quiet", nbytes, 0);
        run3(0, 1'b0);

        // L1 run.
        for (int w = 0; w < 16; w++) mem1[w] = {$urandom, $urandom};
        push_exp1();
        @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int i = 0; i < 2000 && done1_cnt == 0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        chk("l1_done_count", done1_cnt, 1);
        chk("l1_bytes", nbytes1, VS1);
        chk("l1_queue_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_vec_res_unload.md
MAT_VEC_RES_UNLOAD -- requirements
Module: mat_vec_res_unload

Interface
REQ-001 Parameter PARAMETER_SET, default "L3", selects VEC_SIZE_BYTES: L1=126, L3=193, L5=278, other=8.
REQ-002 Parameter VEC_SIZE_BYTES, default derived from PARAMETER_SET; number of bytes emitted per run.
REQ-003 Parameter N_GF, default 8; bytes per result word; PROC_SIZE = N_GF*8.
REQ-004 Derived NWORDS = ceil(VEC_SIZE_BYTES/N_GF); LAST_BYTES = VEC_SIZE_BYTES - (NWORDS-1)*N_GF.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_start  in  1  single-cycle pulse; begins one unload run, normally driven from the multiplier's o_done.
REQ-008 o_res_en  out  1  read enable to the multiplier's result memory (drives its i_res_en).
REQ-009 o_res_addr  out  CLOG2(VEC_SIZE_BYTES*8/PROC_SIZE)  result word address (drives its i_res_addr).
REQ-010 i_res  in  PROC_SIZE  result word; synchronous read, valid the cycle after o_res_en.
REQ-011 o_byte  out  8  output byte.
REQ-012 o_valid  out  1  o_byte valid.
REQ-013 i_ready  in  1  downstream accepts; handshake when o_valid & i_ready.
REQ-014 o_last  out  1  high with the final byte of the run.
REQ-015 o_busy  out  1  high from the cycle after i_start until o_done.
REQ-016 o_done  out  1  one-cycle pulse the cycle after the final handshake.

Function
REQ-017 FSM states IDLE, FETCH, WAIT, SHIFT, DONE; all outputs registered.
REQ-018 IDLE -> FETCH on i_start; i_start outside IDLE is ignored.
REQ-019 FETCH (1 cycle): o_res_en=1, o_res_addr=word index; -> WAIT.
REQ-020 WAIT (1 cycle): i_res captured into shift register at cycle end; -> SHIFT.
REQ-021 SHIFT: byte order MSB-first, byte 0 = word[PROC_SIZE-1 -: 8]; shift by 8 per handshake only.
REQ-022 SHIFT emits N_GF bytes per word, LAST_BYTES for word NWORDS-1; padding bytes never emitted.
REQ-023 After a word's last handshake: -> FETCH with index+1, or -> DONE if index = NWORDS-1.
REQ-024 DONE (1 cycle): o_done=1, o_busy=0; -> IDLE.
REQ-025 With i_ready low, o_byte, o_valid, o_last held stable; o_valid never drops before handshake.
REQ-026 Timing, i_ready=1, i_start in cycle 0: first o_res_en cycle 1, first o_valid cycle 3, each word costs 2+bytes cycles.
REQ-027 o_res_en low outside FETCH; o_res_addr holds last value outside FETCH.
REQ-028 o_last asserted only with byte VEC_SIZE_BYTES-1, never otherwise.

Reset
REQ-029 Async i_rst forces state IDLE, counters 0, shift register 0, all outputs 0, at any time including mid-run.
REQ-030 After reset deassertion, no byte emitted until a new i_start.

Structure
REQ-031 PARAMETER_SET tables and NWORDS/LAST_BYTES derivation reside in the shared parameter package; CLOG2 from the shared header.
REQ-032 Single flat module; no sub-module required; result memory remains external.

Verification
REQ-033 L3, N_GF=8, i_ready=1, i_start cycle 0 -> 193 bytes in memory order, o_last at cycle 243, o_done cycle 244, 25 reads addr 0..24.
REQ-034 Word0=0x0102030405060708 -> bytes 01,02,...,08 in order; last word 0xAA00..00 -> single byte AA with o_last, padding absent.
REQ-035 i_ready toggled pseudo-randomly -> byte stream identical to REQ-033, o_byte stable while o_valid & !i_ready.
REQ-036 i_start re-pulsed mid-run -> ignored, stream and o_done timing unchanged.
REQ-037 i_rst asserted during word 10 -> all outputs 0 same cycle; new i_start -> full correct run from addr 0.
REQ-038 L1 (126 bytes, 16 words, LAST_BYTES=6) -> 126 bytes, o_done exactly once.
